// File: rtl/m_7segled_reader.sv
// Receive side of a multiplexed 7-segment display: decodes stable segment patterns back to digits
// and publishes full frames. Define SEG_HEX_EN to also decode the hex letters A..F.
module m_7segled_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                w_clk,
    input  logic                w_rst,
    input  logic [6:0]          w_seg,
    input  logic [NDIG-1:0]     w_an,
    output logic [4*NDIG-1:0]   r_digits,
    output logic [NDIG-1:0]     r_blank,
    output logic                r_valid,
    output logic                r_err
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

    localparam logic [4:0] STABLE_W = 5'(STABLE);

    state_t              state;
    logic [6:0]          seg_q;
    logic [6:0]          seg_p;
    logic [NDIG-1:0]     an_q;
    logic [NDIG-1:0]     an_p;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic [4*NDIG-1:0]   buf_digits;
    logic [NDIG-1:0]     blank_buf;
    logic [NDIG-1:0]     mask;
    logic [NDIG-1:0]     mask_next;
    logic [NDIG-1:0]     acc_bit;
    logic                an_onehot;
    logic                an_multi;
    logic                same;
    logic                accept;
    logic                acc_ok;
    logic                acc_bad;
    logic [5:0]          dec;

    // Result is {recognised, blank, value}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 6'b10_0000;
            7'b0110000: decode = 6'b10_0001;
            7'b1101101: decode = 6'b10_0010;
            7'b1111001: decode = 6'b10_0011;
            7'b0110011: decode = 6'b10_0100;
            7'b1011011: decode = 6'b10_0101;
            7'b1011111: decode = 6'b10_0110;
            7'b1110000: decode = 6'b10_0111;
            7'b1111111: decode = 6'b10_1000;
            7'b1111011: decode = 6'b10_1001;
            7'b0000000: decode = 6'b11_0000;
`ifdef SEG_HEX_EN
            7'b1110111: decode = 6'b10_1010;
            7'b0011111: decode = 6'b10_1011;
            7'b1001110: decode = 6'b10_1100;
            7'b0111101: decode = 6'b10_1101;
            7'b1001111: decode = 6'b10_1110;
            7'b1000111: decode = 6'b10_1111;
`endif
            default:    decode = 6'b00_0000;
        endcase
    endfunction

    // A digit is accepted only on the sample where its run length first reaches STABLE.
    always_comb begin
        an_onehot = $onehot(an_q);
        an_multi  = !$onehot0(an_q);
        same      = (an_q == an_p) && (seg_q == seg_p);
        cnt_next  = 4'd0;
        accept    = 1'b0;
        if (an_onehot) begin
            if (same) begin
                cnt_next = (cnt == 4'd15) ? cnt : cnt + 4'd1;
                accept   = ({1'b0, cnt} + 5'd1) == STABLE_W;
            end else begin
                cnt_next = 4'd1;
                accept   = (STABLE_W == 5'd1);
            end
        end
        dec       = decode(seg_q);
        acc_ok    = accept & dec[5];
        acc_bad   = accept & ~dec[5];
        acc_bit   = acc_ok ? an_q : '0;
        mask_next = ((state == S_COMMIT) ? '0 : mask) | acc_bit;
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state      <= S_IDLE;
            seg_q      <= '0;
            seg_p      <= '0;
            an_q       <= '0;
            an_p       <= '0;
            cnt        <= '0;
            buf_digits <= '0;
            blank_buf  <= '0;
            mask       <= '0;
            r_digits   <= '0;
            r_blank    <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            seg_q   <= w_seg;
            an_q    <= w_an;
            seg_p   <= seg_q;
            an_p    <= an_q;
            cnt     <= cnt_next;
            r_err   <= an_multi | acc_bad;
            r_valid <= 1'b0;
            mask    <= mask_next;
            for (int k = 0; k < NDIG; k++) begin
                if (acc_bit[k]) begin
                    buf_digits[4*k +: 4] <= dec[3:0];
                    blank_buf[k]         <= dec[4];
                end
            end
            // Commit publishes the old buffer; an accept landing now belongs to the next frame.
            if (state == S_COMMIT) begin
                r_digits <= buf_digits;
                r_blank  <= blank_buf;
                r_valid  <= 1'b1;
            end
            case (state)
                S_IDLE, S_COLLECT, S_COMMIT: begin
                    if (&mask_next)
                        state <= S_COMMIT;
                    else if (|mask_next)
                        state <= S_COLLECT;
                    else
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
